// File: rtl/gpio_int_pkg.sv
// Shared types and helpers for the gpio_int interrupt core.
// The default class widths match the register map in m_gpio_int_cfg.
package gpio_int_pkg;

    localparam int SK_W_DEF  = 8;
    localparam int INF_W_DEF = 48;
    localparam int ERR_W_DEF = 40;
    localparam int POP_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } irq_state_e;

    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/gpio_int_edge_pend.sv
// Per-class source edge detector with sticky W1C pending bits.
// Also produces the registered masked-OR level interrupt for the class.
module gpio_int_edge_pend #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] src_i,
    input  logic [W-1:0] mask_i,
    input  logic         clr_vld_i,
    input  logic [W-1:0] clr_i,
    output logic [W-1:0] pend_o,
    output logic [W-1:0] rise_o,
    output logic         int_o
);

    logic [W-1:0] srcHist_q;
    logic [W-1:0] pend_q;
    logic [W-1:0] pend_d;
    logic [W-1:0] clrEff;
    logic         int_q;

    // A same-cycle rise wins over a clear, so the OR comes last.
    assign rise_o = src_i & ~srcHist_q;
    assign clrEff = clr_vld_i ? clr_i : '0;
    assign pend_d = (pend_q & ~clrEff) | rise_o;

    // History reloads during reset too, so a level held across reset is not an edge.
    always_ff @(posedge clk_i) begin
        srcHist_q <= src_i;
        if (rst_i) begin
            pend_q <= '0;
            int_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            int_q  <= |(pend_q & ~mask_i);
        end
    end

    assign pend_o = pend_q;
    assign int_o  = int_q;

endmodule

// File: rtl/gpio_int_ctrl.sv
// Interrupt core of gpio_int: sticky pending per class, level interrupts,
// a paced CPU pulse, the lowest pending error index and an error edge counter.
module gpio_int_ctrl
    import gpio_int_pkg::*;
#(
    parameter int SK_W    = SK_W_DEF,
    parameter int INF_W   = INF_W_DEF,
    parameter int ERR_W   = ERR_W_DEF,
    parameter int IRQ_PW  = 4,
    parameter int IRQ_GAP = 8
) (
    input  logic                     clk_50m,
    input  logic                     rst_50m,
    input  logic [SK_W-1:0]          sh_src,
    input  logic [INF_W-1:0]         info_src,
    input  logic [ERR_W-1:0]         err_src,
    input  logic [SK_W-1:0]          sh_mask,
    input  logic [INF_W-1:0]         info_mask,
    input  logic [ERR_W-1:0]         err_mask,
    input  logic                     clr_vld,
    input  logic [SK_W-1:0]          clr_sh,
    input  logic [INF_W-1:0]         clr_info,
    input  logic [ERR_W-1:0]         clr_err,
    output logic [SK_W-1:0]          pend_sh,
    output logic [INF_W-1:0]         pend_info,
    output logic [ERR_W-1:0]         pend_err,
    output logic                     int_sh,
    output logic                     int_info,
    output logic                     int_err,
    output logic                     irq_pulse,
    output logic [$clog2(ERR_W)-1:0] err_first_idx,
    output logic [15:0]              err_cnt
);

    localparam int IDX_W   = $clog2(ERR_W);
    localparam int CNT_MAX = (IRQ_PW > IRQ_GAP) ? IRQ_PW : IRQ_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(IRQ_PW - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(IRQ_GAP - 1);

    logic [SK_W-1:0]  riseSh;
    logic [INF_W-1:0] riseInfo;
    logic [ERR_W-1:0] riseErr;
    logic [ERR_W-1:0] errActive;
    logic             newEvt_d;
    logic             newEvt_q;
    irq_state_e       state_q;
    irq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             evtPend_q;
    logic             evtPend_d;
    logic [IDX_W-1:0] firstIdx_d;
    logic [IDX_W-1:0] firstIdx_q;
    logic [6:0]       riseErrCnt;
    logic [16:0]      errSum;
    logic [15:0]      errCnt_d;
    logic [15:0]      errCnt_q;

    gpio_int_edge_pend #(.W(SK_W)) u_sh (
        .clk_i     (clk_50m),
        .rst_i     (rst_50m),
        .src_i     (sh_src),
        .mask_i    (sh_mask),
        .clr_vld_i (clr_vld),
        .clr_i     (clr_sh),
        .pend_o    (pend_sh),
        .rise_o    (riseSh),
        .int_o     (int_sh)
    );

    gpio_int_edge_pend #(.W(INF_W)) u_info (
        .clk_i     (clk_50m),
        .rst_i     (rst_50m),
        .src_i     (info_src),
        .mask_i    (info_mask),
        .clr_vld_i (clr_vld),
        .clr_i     (clr_info),
        .pend_o    (pend_info),
        .rise_o    (riseInfo),
        .int_o     (int_info)
    );

    gpio_int_edge_pend #(.W(ERR_W)) u_err (
        .clk_i     (clk_50m),
        .rst_i     (rst_50m),
        .src_i     (err_src),
        .mask_i    (err_mask),
        .clr_vld_i (clr_vld),
        .clr_i     (clr_err),
        .pend_o    (pend_err),
        .rise_o    (riseErr),
        .int_o     (int_err)
    );

    // Only fresh unmasked edges count as events; unmasking an old pending bit does not.
    assign newEvt_d = (|(riseSh & ~sh_mask)) | (|(riseInfo & ~info_mask)) |
                      (|(riseErr & ~err_mask));

    always_ff @(posedge clk_50m) begin
        if (rst_50m) begin
            newEvt_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            evtPend_q <= 1'b0;
        end else begin
            newEvt_q  <= newEvt_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            evtPend_q <= evtPend_d;
        end
    end

    // Events arriving while a pulse or gap is running merge into one follow-up pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        evtPend_d = evtPend_q;
        case (state_q)
            IDLE: begin
                if (newEvt_q) begin
                    state_d = PULSE;
                    cnt_d   = PW_LOAD;
                end
            end
            PULSE: begin
                evtPend_d = evtPend_q | newEvt_q;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                evtPend_d = evtPend_q | newEvt_q;
                if (cnt_q == '0) begin
                    if (evtPend_q | newEvt_q) begin
                        state_d   = PULSE;
                        cnt_d     = PW_LOAD;
                        evtPend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                evtPend_d = 1'b0;
            end
        endcase
    end

    assign irq_pulse = (state_q == PULSE);

    // Scan from the top down so the lowest active index is the last one written.
    assign errActive = pend_err & ~err_mask;

    always_comb begin
        firstIdx_d = '0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (errActive[i]) begin
                firstIdx_d = IDX_W'(i);
            end
        end
    end

    assign riseErrCnt = popcount(POP_W'(riseErr));
    assign errSum     = {1'b0, errCnt_q} + 17'(riseErrCnt);
    assign errCnt_d   = errSum[16] ? 16'hFFFF : errSum[15:0];

    always_ff @(posedge clk_50m) begin
        if (rst_50m) begin
            firstIdx_q <= '0;
            errCnt_q   <= '0;
        end else begin
            firstIdx_q <= firstIdx_d;
            errCnt_q   <= errCnt_d;
        end
    end

    assign err_first_idx = firstIdx_q;
    assign err_cnt       = errCnt_q;

endmodule

// File: tb/tb_gpio_int_ctrl.sv
// Self-checking bench for gpio_int_ctrl: a directed vector table, hand-written
// corner sequences and randomized traffic, all compared against a behavioural model.
module tb_gpio_int_ctrl;

    localparam int SK_W    = 8;
    localparam int INF_W   = 48;
    localparam int ERR_W   = 40;
    localparam int IRQ_PW  = 4;
    localparam int IRQ_GAP = 8;
    localparam int IDX_W   = $clog2(ERR_W);

    logic              clk_50m = 1'b0;
    logic              rst_50m;
    logic [SK_W-1:0]   sh_src, sh_mask, clr_sh, pend_sh;
    logic [INF_W-1:0]  info_src, info_mask, clr_info, pend_info;
    logic [ERR_W-1:0]  err_src, err_mask, clr_err, pend_err;
    logic              clr_vld;
    logic              int_sh, int_info, int_err, irq_pulse;
    logic [IDX_W-1:0]  err_first_idx;
    logic [15:0]       err_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state: what each output should read after the last edge.
    logic [SK_W-1:0]  mPrevSh, mPendSh;
    logic [INF_W-1:0] mPrevInfo, mPendInfo;
    logic [ERR_W-1:0] mPrevErr, mPendErr;
    logic [2:0]       mInt;
    logic             mNew;
    int               mIdx, mCnt, mPhase;
    bit               mActive, mOwed;

    typedef struct {
        logic rst;
        logic info40;
        logic err3;
        logic clrVld;
        logic clr3;
        logic expPend3;
        logic expInt;
        logic expIrq;
        int   expIdx;
        int   expCnt;
    } vec_t;

    vec_t tbl[$];

    gpio_int_ctrl #(
        .SK_W(SK_W), .INF_W(INF_W), .ERR_W(ERR_W), .IRQ_PW(IRQ_PW), .IRQ_GAP(IRQ_GAP)
    ) dut (
        .clk_50m       (clk_50m),
        .rst_50m       (rst_50m),
        .sh_src        (sh_src),
        .info_src      (info_src),
        .err_src       (err_src),
        .sh_mask       (sh_mask),
        .info_mask     (info_mask),
        .err_mask      (err_mask),
        .clr_vld       (clr_vld),
        .clr_sh        (clr_sh),
        .clr_info      (clr_info),
        .clr_err       (clr_err),
        .pend_sh       (pend_sh),
        .pend_info     (pend_info),
        .pend_err      (pend_err),
        .int_sh        (int_sh),
        .int_info      (int_info),
        .int_err       (int_err),
        .irq_pulse     (irq_pulse),
        .err_first_idx (err_first_idx),
        .err_cnt       (err_cnt)
    );

    always #5 clk_50m = ~clk_50m;

    function automatic vec_t mk(logic rst, logic info40, logic err3, logic cv, logic c3,
                                logic p3, logic ie, logic iq, int idx, int cnt);
        vec_t v;
        v.rst = rst; v.info40 = info40; v.err3 = err3; v.clrVld = cv; v.clr3 = c3;
        v.expPend3 = p3; v.expInt = ie; v.expIrq = iq; v.expIdx = idx; v.expCnt = cnt;
        return v;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_50m   = v.rst;
        sh_src    = '0;
        info_src  = '0;
        info_src[40] = v.info40;
        err_src   = '0;
        err_src[3] = v.err3;
        sh_mask   = '0;
        info_mask = '0;
        err_mask  = '0;
        clr_vld   = v.clrVld;
        clr_sh    = '0;
        clr_info  = '0;
        clr_err   = '0;
        clr_err[3] = v.clr3;
    endtask

    // Advance one clock: predict from the rules, clock the DUT, then compare everything.
    task automatic tick();
        logic [SK_W-1:0]  rSh, nSh;
        logic [INF_W-1:0] rInfo, nInfo;
        logic [ERR_W-1:0] rErr, nErr, actErr;
        logic [2:0]       nInt;
        logic             nNew;
        int               nIdx, nCnt, nPhase;
        bit               nActive, nOwed;
        nActive = mActive;
        nOwed   = mOwed;
        nPhase  = mPhase;
        if (rst_50m) begin
            nSh = '0; nInfo = '0; nErr = '0; nInt = '0; nNew = 1'b0;
            nIdx = 0; nCnt = 0; nActive = 0; nOwed = 0; nPhase = 0;
        end else begin
            rSh   = sh_src & ~mPrevSh;
            rInfo = info_src & ~mPrevInfo;
            rErr  = err_src & ~mPrevErr;
            nSh   = (mPendSh & ~(clr_vld ? clr_sh : '0)) | rSh;
            nInfo = (mPendInfo & ~(clr_vld ? clr_info : '0)) | rInfo;
            nErr  = (mPendErr & ~(clr_vld ? clr_err : '0)) | rErr;
            nInt  = {|(mPendSh & ~sh_mask), |(mPendInfo & ~info_mask), |(mPendErr & ~err_mask)};
            nNew  = (|(rSh & ~sh_mask)) || (|(rInfo & ~info_mask)) || (|(rErr & ~err_mask));
            actErr = mPendErr & ~err_mask;
            nIdx = 0;
            for (int i = 0; i < ERR_W; i++) begin
                if (actErr[i]) begin
                    nIdx = i;
                    break;
                end
            end
            nCnt = mCnt + $countones(rErr);
            if (nCnt > 65535) nCnt = 65535;
            if (!mActive) begin
                if (mNew) begin
                    nActive = 1;
                    nPhase  = 0;
                end
            end else begin
                nPhase = mPhase + 1;
                if (mNew) nOwed = 1;
                if (nPhase == IRQ_PW + IRQ_GAP) begin
                    if (nOwed) begin
                        nPhase = 0;
                        nOwed  = 0;
                    end else begin
                        nActive = 0;
                    end
                end
            end
        end
        mPrevSh = sh_src; mPrevInfo = info_src; mPrevErr = err_src;
        @(posedge clk_50m);
        #1;
        mPendSh = nSh; mPendInfo = nInfo; mPendErr = nErr; mInt = nInt; mNew = nNew;
        mIdx = nIdx; mCnt = nCnt; mActive = nActive; mOwed = nOwed; mPhase = nPhase;
        checkOutput("pend_sh", 64'(pend_sh), 64'(mPendSh));
        checkOutput("pend_info", 64'(pend_info), 64'(mPendInfo));
        checkOutput("pend_err", 64'(pend_err), 64'(mPendErr));
        checkOutput("int_vec", 64'({int_sh, int_info, int_err}), 64'(mInt));
        checkOutput("irq_pulse", 64'(irq_pulse), 64'(mActive && (mPhase < IRQ_PW)));
        checkOutput("err_first_idx", 64'(err_first_idx), 64'(mIdx));
        checkOutput("err_cnt", 64'(err_cnt), 64'(mCnt));
    endtask

    task automatic doReset();
        rst_50m = 1'b1;
        sh_src = '0; info_src = '0; err_src = '0;
        sh_mask = '0; info_mask = '0; err_mask = '0;
        clr_vld = 1'b0; clr_sh = '0; clr_info = '0; clr_err = '0;
        tick();
        tick();
        rst_50m = 1'b0;
    endtask

    initial begin
        logic irqLog[$];
        int   edges, firstFall, secondRise;

        mPrevSh = '0; mPendSh = '0; mPrevInfo = '0; mPendInfo = '0;
        mPrevErr = '0; mPendErr = '0; mInt = '0; mNew = 1'b0;
        mIdx = 0; mCnt = 0; mPhase = 0; mActive = 0; mOwed = 0;

        // Directed table: reset with info_src[40] held, one error pulse, W1C behaviour.
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0, 1,0,0,0,1));
        tbl.push_back(mk(0,1,1,0,0, 1,1,1,3,1));
        tbl.push_back(mk(0,1,1,0,0, 1,1,1,3,1));
        tbl.push_back(mk(0,1,1,0,0, 1,1,1,3,1));
        tbl.push_back(mk(0,1,1,0,0, 1,1,1,3,1));
        tbl.push_back(mk(0,1,1,0,0, 1,1,0,3,1));
        tbl.push_back(mk(0,1,0,0,0, 1,1,0,3,1));
        tbl.push_back(mk(0,1,1,1,1, 1,1,0,3,2));
        tbl.push_back(mk(0,1,1,0,1, 1,1,0,3,2));
        tbl.push_back(mk(0,1,1,1,1, 0,1,0,3,2));
        tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,2));
        tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,2));
        tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,2));
        for (int k = 0; k < 4; k++) tbl.push_back(mk(0,1,1,0,0, 0,0,1,0,2));
        for (int k = 0; k < 9; k++) tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,2));

        for (int k = 0; k < tbl.size(); k++) begin
            applyStimulus(tbl[k]);
            tick();
            checkOutput($sformatf("row%0d_pend_err3", k), 64'(pend_err[3]), 64'(tbl[k].expPend3));
            checkOutput($sformatf("row%0d_pend_info", k), 64'(pend_info), 64'd0);
            checkOutput($sformatf("row%0d_int_err", k), 64'(int_err), 64'(tbl[k].expInt));
            checkOutput($sformatf("row%0d_irq", k), 64'(irq_pulse), 64'(tbl[k].expIrq));
            checkOutput($sformatf("row%0d_idx", k), 64'(err_first_idx), 64'(tbl[k].expIdx));
            checkOutput($sformatf("row%0d_cnt", k), 64'(err_cnt), 64'(tbl[k].expCnt));
        end

        // Masked shutdown source: pends silently, unmasking raises int_sh but no pulse.
        doReset();
        sh_mask[5] = 1'b1;
        sh_src[5]  = 1'b1;
        tick();
        checkOutput("masked_pend_sh5", 64'(pend_sh[5]), 64'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("masked_int_sh", 64'(int_sh), 64'd0);
            checkOutput("masked_irq", 64'(irq_pulse), 64'd0);
        end
        sh_mask[5] = 1'b0;
        tick();
        checkOutput("unmask_int_sh", 64'(int_sh), 64'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("unmask_irq", 64'(irq_pulse), 64'd0);
        end

        // Three events two cycles apart merge into exactly two pulses with an 8-cycle gap.
        doReset();
        for (int k = 0; k < 40; k++) begin
            if (k == 0) info_src[0] = 1'b1;
            if (k == 2) info_src[1] = 1'b1;
            if (k == 4) info_src[2] = 1'b1;
            tick();
            irqLog.push_back(irq_pulse);
        end
        edges = 0; firstFall = -1; secondRise = -1;
        for (int k = 1; k < irqLog.size(); k++) begin
            if (irqLog[k] && !irqLog[k-1]) begin
                edges++;
                if (edges == 2) secondRise = k;
            end
            if (!irqLog[k] && irqLog[k-1] && firstFall < 0) firstFall = k;
        end
        checkOutput("merge_pulse_count", 64'(edges), 64'd2);
        checkOutput("merge_gap_len", 64'(secondRise - firstFall), 64'(IRQ_GAP));

        // Reset in the middle of a pulse with a merged event owed: nothing survives.
        doReset();
        err_src[7] = 1'b1;
        tick();
        info_src[9] = 1'b1;
        tick();
        checkOutput("midrst_irq_hi0", 64'(irq_pulse), 64'd1);
        tick();
        checkOutput("midrst_irq_hi1", 64'(irq_pulse), 64'd1);
        rst_50m = 1'b1;
        tick();
        checkOutput("midrst_irq_drop", 64'(irq_pulse), 64'd0);
        rst_50m = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput("midrst_irq_quiet", 64'(irq_pulse), 64'd0);
        end

        // Randomized traffic against the model.
        doReset();
        for (int k = 0; k < 2000; k++) begin
            logic [63:0] t;
            if ((k % 50) == 0) begin
                t = rnd64(); sh_mask = t[SK_W-1:0];
                t = rnd64(); info_mask = t[INF_W-1:0];
                t = rnd64(); err_mask = t[ERR_W-1:0];
            end
            t = rnd64() & rnd64() & rnd64() & rnd64(); sh_src   = sh_src ^ t[SK_W-1:0];
            t = rnd64() & rnd64() & rnd64() & rnd64(); info_src = info_src ^ t[INF_W-1:0];
            t = rnd64() & rnd64() & rnd64() & rnd64(); err_src  = err_src ^ t[ERR_W-1:0];
            clr_vld = ($urandom_range(0, 3) == 0);
            t = rnd64(); clr_sh   = t[SK_W-1:0];
            t = rnd64(); clr_info = t[INF_W-1:0];
            t = rnd64(); clr_err  = t[ERR_W-1:0];
            rst_50m = ($urandom_range(0, 99) < 2);
            tick();
        end

        // Error edge counter saturates and stays pinned.
        doReset();
        err_mask = '1;
        for (int k = 0; k < 1700; k++) begin
            err_src = '1;
            tick();
            err_src = '0;
            tick();
        end
        checkOutput("err_cnt_saturated", 64'(err_cnt), 64'hFFFF);
        err_src[0] = 1'b1;
        tick();
        checkOutput("err_cnt_no_wrap", 64'(err_cnt), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
